// File: rtl/uart_tx_feeder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_feeder
//
// Byte FIFO and launch sequencer sitting directly in front of the byte-wide
// UART transmitter. Producers push bytes at clock rate; the block buffers them
// in a circular buffer and hands them to the transmitter one at a time using
// the trmt / tx_data / tx_done handshake, back to back, with no producer
// involvement. A push into a full FIFO is dropped and flagged on a sticky ovfl.
//
// Parameters
//   DEPTH     FIFO entries, power of two, 2..256
//
// Ports
//   clk       system clock, all logic on the rising edge
//   rst_n     asynchronous active-low reset (also resets the transmitter)
//   wr_en     push wr_data this cycle
//   wr_data   byte to enqueue
//   full      FIFO holds DEPTH entries
//   empty     FIFO holds no entries
//   count     current occupancy, 0..DEPTH
//   ovfl      sticky flag: a push was attempted while full
//   clr_ovfl  synchronous clear of ovfl (a same-cycle overflow wins)
//   trmt      one-cycle launch strobe to the transmitter
//   tx_data   registered byte presented to the transmitter
//   tx_done   transmitter level flag; rises at frame end, clears on trmt
//   busy      sequencer not idle, or bytes still queued
// -----------------------------------------------------------------------------
module uart_tx_feeder #(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [7:0]              wr_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    ovfl,
    input  logic                    clr_ovfl,
    output logic                    trmt,
    output logic [7:0]              tx_data,
    input  logic                    tx_done,
    output logic                    busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    // Sequencer state
    state_t         state_q, state_d;

    // FIFO bookkeeping
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q,  count_d;
    logic           ovfl_q,   ovfl_d;

    // Transmitter-facing registers
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_done_q, tx_done_d;

    // Storage
    logic [7:0]     mem [DEPTH];

    // Decodes
    logic           full_w;
    logic           empty_w;
    logic           push;
    logic           pop;
    logic           done_rise;

    // -------------------------------------------------------------------------
    // Status decodes, all from registered count so a pop in the same cycle
    // never lets a push into a full buffer.
    // -------------------------------------------------------------------------
    assign full_w    = (count_q == CNT_FULL);
    assign empty_w   = (count_q == CNT_ZERO);
    assign push      = wr_en && !full_w;

    // Completion is only the rising edge of the level flag; a transmitter that
    // leaves tx_done high must not be seen as a stream of completions.
    assign done_rise = tx_done && !tx_done_q;
    assign tx_done_d = tx_done;

    // -------------------------------------------------------------------------
    // Sequencer next state. Pops happen only here, so there is no bypass from
    // wr_data to tx_data: every byte goes through storage.
    // -------------------------------------------------------------------------
    // NOTE: every variable written in an always_comb gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_w) begin
                    pop     = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise) begin
                    if (!empty_w) begin
                        pop     = 1'b1;
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FIFO pointers, occupancy, overflow flag and output byte.
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovfl_d    = ovfl_q;
        tx_data_d = tx_data_q;

        // Pointers wrap naturally since DEPTH is a power of two.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            tx_data_d = mem[rd_ptr_q];
        end

        // Simultaneous push and pop leaves occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A dropped push sets the flag even if clr_ovfl is asserted with it.
        if (wr_en && full_w) begin
            ovfl_d = 1'b1;
        end else if (clr_ovfl) begin
            ovfl_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Storage array.
    // -------------------------------------------------------------------------
    // NOTE: the byte array is deliberately left out of reset; only pointers and
    // count define which entries are valid, and a resettable array would turn
    // a simple RAM into DEPTH x 8 reset flops.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovfl_q    <= 1'b0;
            tx_data_q <= 8'h00;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovfl_q    <= ovfl_d;
            tx_data_q <= tx_data_d;
            tx_done_q <= tx_done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. trmt is a pure decode of the state register, so it carries no
    // combinational path from any input.
    // -------------------------------------------------------------------------
    assign trmt    = (state_q == S_LAUNCH);
    assign tx_data = tx_data_q;
    assign full    = full_w;
    assign empty   = empty_w;
    assign count   = count_q;
    assign ovfl    = ovfl_q;
    assign busy    = (state_q != S_IDLE) || !empty_w;

    // -------------------------------------------------------------------------
    // Structural invariants.
    // -------------------------------------------------------------------------
    a_trmt_single: assert property (@(posedge clk) disable iff (!rst_n)
        trmt |=> !trmt);

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CNT_FULL);

endmodule

// File: tb/tb_uart_tx_feeder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_tx_feeder
//
// Drives uart_tx_feeder (DEPTH=8) against a simple transmitter model. The
// reference is a queue of accepted bytes: every trmt pops the head and the
// presented byte must match; occupancy, flags and busy follow from the queue
// length, the sticky-overflow rule and whether a frame is in flight.
// -----------------------------------------------------------------------------
module tb_uart_tx_feeder;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          ovfl;
    logic          clr_ovfl;
    logic          trmt;
    logic [7:0]    tx_data;
    logic          tx_done;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] exp_q[$];     // accepted bytes not yet launched
    logic [7:0] last_tx;      // byte the transmitter should currently see
    logic       exp_ovfl;
    logic       in_flight;    // a launched frame not yet completed
    logic       rise_pending; // tx_done rose at this negedge
    logic       last_trmt;
    int         pulses;

    // Transmitter model state
    int         xm_left;
    int         stuck_left;
    bit         stuck_arm;
    int         lat_lo;
    int         lat_hi;

    int         p0;
    int         sent;
    int         guard;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .ovfl     (ovfl),
        .clr_ovfl (clr_ovfl),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_tx      = 8'h00;
        exp_ovfl     = 1'b0;
        in_flight    = 1'b0;
        rise_pending = 1'b0;
        last_trmt    = 1'b0;
        xm_left      = 0;
        stuck_left   = 0;
        stuck_arm    = 1'b0;
        tx_done      = 1'b0;
        wr_en        = 1'b0;
        clr_ovfl     = 1'b0;
        wr_data      = 8'h00;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_count"},   32'(count),   32'd0);
        check({tag, "_empty"},   32'(empty),   32'd1);
        check({tag, "_full"},    32'(full),    32'd0);
        check({tag, "_ovfl"},    32'(ovfl),    32'd0);
        check({tag, "_trmt"},    32'(trmt),    32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
    endtask

    // One clock: at the falling edge observe and check, advance the
    // transmitter model, then drive the next inputs and predict their effect.
    task automatic step(input logic we, input logic [7:0] d, input logic clr);
        @(negedge clk);

        if (rise_pending) in_flight = 1'b0;
        rise_pending = 1'b0;

        if (in_flight) check("trmt_in_wait", 32'(trmt), 32'd0);
        last_trmt = trmt;
        if (trmt) begin
            pulses++;
            in_flight = 1'b1;
            if (exp_q.size() == 0) check("trmt_no_data", 32'(trmt), 32'd0);
            else last_tx = exp_q.pop_front();
        end

        check("tx_data", 32'(tx_data), 32'(last_tx));
        check("count",   32'(count),   32'(exp_q.size()));
        check("full",    32'(full),    32'(exp_q.size() == DEPTH));
        check("empty",   32'(empty),   32'(exp_q.size() == 0));
        check("ovfl",    32'(ovfl),    32'(exp_ovfl));
        check("busy",    32'(busy),    32'(in_flight || (exp_q.size() != 0)));

        // Transmitter: trmt clears tx_done and starts a frame; tx_done rises
        // when the frame ends and stays high until the next trmt.
        if (trmt) begin
            if (stuck_left == 0) tx_done = 1'b0;
            xm_left = int'($urandom_range(lat_hi, lat_lo));
        end else if (stuck_left > 0) begin
            stuck_left--;
            if (stuck_left == 0) tx_done = 1'b0;
        end else if (xm_left > 0) begin
            xm_left--;
            if (xm_left == 0) begin
                rise_pending = !tx_done;
                tx_done      = 1'b1;
                if (stuck_arm) begin
                    stuck_arm  = 1'b0;
                    stuck_left = 50;
                end
            end
        end

        wr_en    = we;
        wr_data  = d;
        clr_ovfl = clr;
        if (we && (exp_q.size() == DEPTH)) begin
            exp_ovfl = 1'b1;
        end else begin
            if (we)  exp_q.push_back(d);
            if (clr) exp_ovfl = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_flight || rise_pending) && n < 3000) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        check({tag, "_drained"}, 32'(n < 3000), 32'd1);
    endtask

    initial begin
        rst_n  = 1'b0;
        pulses = 0;
        lat_lo = 2;
        lat_hi = 2;
        model_reset();

        // Power-on reset
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;

        // Single byte: latency and a single pulse
        lat_lo = 6; lat_hi = 6;
        repeat (3) step(1'b0, 8'h00, 1'b0);
        p0 = pulses;
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("single_k_trmt",  32'(last_trmt), 32'd0);
        check("single_k_count", 32'(count),     32'd1);
        step(1'b0, 8'h00, 1'b0);
        check("single_k1_trmt", 32'(last_trmt), 32'd1);
        check("single_data",    32'(tx_data),   32'h00A5);
        step(1'b0, 8'h00, 1'b0);
        check("single_k2_trmt", 32'(last_trmt), 32'd0);
        drain("single");
        step(1'b0, 8'h00, 1'b0);
        check("single_busy",   32'(busy),        32'd0);
        check("single_pulses", 32'(pulses - p0), 32'd1);

        // Burst behind a slow primer frame, then overflow handling
        lat_lo = 40; lat_hi = 40;
        p0 = pulses;
        step(1'b1, 8'hEE, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("primer_trmt", 32'(last_trmt), 32'd1);
        lat_lo = 3; lat_hi = 3;
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("burst_full",  32'(full),  32'd1);
        check("burst_count", 32'(count), 32'd8);
        step(1'b1, 8'hFF, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("ovfl_set",   32'(ovfl),  32'd1);
        check("ovfl_count", 32'(count), 32'd8);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check("ovfl_clr", 32'(ovfl), 32'd0);
        step(1'b1, 8'hFF, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check("ovfl_set_wins", 32'(ovfl), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        drain("burst");
        step(1'b0, 8'h00, 1'b0);
        check("burst_pulses", 32'(pulses - p0), 32'd9);
        check("burst_empty",  32'(empty),       32'd1);
        check("burst_busy",   32'(busy),        32'd0);

        // Low occupancy streaming: pointers wrap twice
        lat_lo = 1; lat_hi = 3;
        p0 = pulses; sent = 0; guard = 0;
        while (sent < 20 && guard < 1000) begin
            if (exp_q.size() < 2) begin
                step(1'b1, 8'($urandom), 1'b0);
                sent++;
            end else begin
                step(1'b0, 8'h00, 1'b0);
            end
            guard++;
        end
        check("wrap_sent", 32'(sent), 32'd20);
        drain("wrap");
        check("wrap_pulses", 32'(pulses - p0), 32'd20);

        // tx_done held high: one completion only
        lat_lo = 4; lat_hi = 4;
        p0 = pulses;
        stuck_arm = 1'b1;
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'hC3, 1'b0);
        repeat (25) step(1'b0, 8'h00, 1'b0);
        check("stuck_pulses_mid", 32'(pulses - p0), 32'd2);
        check("stuck_busy_mid",   32'(busy),        32'd1);
        drain("stuck");
        step(1'b0, 8'h00, 1'b0);
        check("stuck_pulses", 32'(pulses - p0), 32'd2);
        check("stuck_busy",   32'(busy),        32'd0);

        // Reset mid-frame with three bytes queued
        lat_lo = 30; lat_hi = 30;
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("prereset_count", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("midreset");
        repeat (3) @(negedge clk);
        check_reset_values("held");
        rst_n = 1'b1;
        p0 = pulses;
        repeat (20) step(1'b0, 8'h00, 1'b0);
        check("postreset_quiet", 32'(pulses - p0), 32'd0);

        // Randomized traffic including overflow and clears
        lat_lo = 1; lat_hi = 12;
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(99, 0) < 30, 8'($urandom), $urandom_range(99, 0) < 4);
        end
        drain("random");
        step(1'b0, 8'h00, 1'b0);
        check("random_empty", 32'(empty), 32'd1);
        check("random_busy",  32'(busy),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
